// File: rtl/lstm_pkg.sv
// Shared Q6.11 number format and sequencer state encoding for the LSTM datapath.
package lstm_pkg;

  localparam int Q_WIDTH = 18;
  localparam int Q_FRAC  = 11;

  typedef logic signed [Q_WIDTH-1:0] q6_11_t;

  typedef enum logic [1:0] {IDLE, WAIT, CAP, OUT} seq_state_e;

endpackage

// File: rtl/lstm_seq_sequencer.sv
// Feeds x_t/h_prev/c_prev to one LSTM cell and captures h_t/c_t back; m_valid from accept+CELL_LAT+2, one step in flight.
// s_ready stays low until m_h is taken; s_last clears state. LSTM_SEQ_INIT_STATE_EN adds init_h/init_c state seeds.
module lstm_seq_sequencer
  import lstm_pkg::*;
#(
  parameter int WIDTH    = Q_WIDTH,
  parameter int FRAC     = Q_FRAC,
  parameter int CELL_LAT = 1,
  parameter int STEP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_x,
  input  logic              s_last,
  output logic [WIDTH-1:0]  cell_x,
  output logic [WIDTH-1:0]  cell_h_prev,
  output logic [WIDTH-1:0]  cell_c_prev,
  input  logic [WIDTH-1:0]  cell_h_t,
  input  logic [WIDTH-1:0]  cell_c_t,
`ifdef LSTM_SEQ_INIT_STATE_EN
  input  logic [WIDTH-1:0]  init_h,
  input  logic [WIDTH-1:0]  init_c,
`endif
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_h,
  output logic              m_last,
  output logic [STEP_W-1:0] m_step
);

  localparam int CNT_W = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;

  if (CELL_LAT < 1 || FRAC >= WIDTH) begin : g_param_check
    $error("lstm_seq_sequencer: CELL_LAT must be >= 1 and FRAC < WIDTH");
  end

  seq_state_e        state, state_nxt;
  logic              accept, leave, init_load;
  logic [CNT_W-1:0]  wait_cnt;
  logic              last_q;
  logic [WIDTH-1:0]  h_st, c_st, h_init, c_init;
  logic [STEP_W-1:0] step_cnt;

`ifdef LSTM_SEQ_INIT_STATE_EN
  assign h_init = init_h;
  assign c_init = init_c;
  // s_ready is low in IDLE only on the first cycle after reset release.
  assign init_load = (state == IDLE) && !s_ready;
`else
  assign h_init    = '0;
  assign c_init    = '0;
  assign init_load = 1'b0;
`endif

  assign cell_h_prev = h_st;
  assign cell_c_prev = c_st;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    leave     = 1'b0;
    case (state)
      IDLE: if (s_valid && s_ready) begin
        accept    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (wait_cnt == '0) state_nxt = CAP;
      CAP:  state_nxt = OUT;
      OUT:  if (m_ready) begin
        leave     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_ready <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_x   <= '0;
      last_q   <= 1'b0;
      wait_cnt <= '0;
      h_st     <= '0;
      c_st     <= '0;
      step_cnt <= '0;
      m_valid  <= 1'b0;
      m_h      <= '0;
      m_last   <= 1'b0;
      m_step   <= '0;
    end else begin
      if (accept) begin
        cell_x   <= s_x;
        last_q   <= s_last;
        wait_cnt <= CNT_W'(CELL_LAT - 1);
      end
      if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
      if (state == CAP) begin
        h_st    <= cell_h_t;
        c_st    <= cell_c_t;
        m_h     <= cell_h_t;
        m_last  <= last_q;
        m_step  <= step_cnt;
        m_valid <= 1'b1;
      end
      if (leave) begin
        m_valid <= 1'b0;
        if (last_q) begin
          h_st     <= h_init;
          c_st     <= c_init;
          step_cnt <= '0;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
      if (init_load) begin
        h_st <= h_init;
        c_st <= c_init;
      end
    end
  end

endmodule
